// File: rtl/alu_scheduler.sv
// Round-robin front end for one shared 3-bit signed ALU used by two requesters.
// Operands are held in registers while the ALU works; the result goes back over valid/ready, tagged with the requester ID.
module alu_scheduler #(
    parameter int NBITS_DATA = 3,
    parameter int NBITS_OP   = 2,
    parameter int NBITS_OVF  = 4
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [NBITS_DATA-1:0] req0_a,
    input  logic [NBITS_DATA-1:0] req0_b,
    input  logic [NBITS_OP-1:0]   req0_f,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [NBITS_DATA-1:0] req1_a,
    input  logic [NBITS_DATA-1:0] req1_b,
    input  logic [NBITS_OP-1:0]   req1_f,
    output logic [NBITS_DATA-1:0] alu_a,
    output logic [NBITS_DATA-1:0] alu_b,
    output logic [NBITS_OP-1:0]   alu_f,
    input  logic [NBITS_DATA-1:0] alu_y,
    input  logic                  alu_flow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [NBITS_DATA-1:0] rsp_y,
    output logic                  rsp_flow,
    output logic                  busy,
    output logic [NBITS_OVF-1:0]  ovf_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [NBITS_OVF-1:0] OVF_MAX = '1;

    state_t                state_q;
    logic                  last_grant_q;
    logic [NBITS_DATA-1:0] op_a_q, op_b_q;
    logic [NBITS_OP-1:0]   op_f_q;
    logic                  op_id_q;
    logic [NBITS_DATA-1:0] rsp_y_q;
    logic                  rsp_flow_q, rsp_id_q, rsp_valid_q;
    logic [NBITS_OVF-1:0]  ovf_q;

    logic sel, accept;

    // On contention the requester that did not win last time goes next.
    always_comb begin
        sel = req1_valid;
        if (req0_valid && req1_valid) sel = ~last_grant_q;
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !sel;
    assign req1_ready = (state_q == IDLE) && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_f_q       <= '0;
            op_id_q      <= 1'b0;
            rsp_y_q      <= '0;
            rsp_flow_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            ovf_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_a_q       <= sel ? req1_a : req0_a;
                        op_b_q       <= sel ? req1_b : req0_b;
                        op_f_q       <= sel ? req1_f : req0_f;
                        op_id_q      <= sel;
                        last_grant_q <= sel;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y_q     <= alu_y;
                    rsp_flow_q  <= alu_flow;
                    rsp_id_q    <= op_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        if (rsp_flow_q && (ovf_q != OVF_MAX)) ovf_q <= ovf_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;
    assign alu_f     = op_f_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flow  = rsp_flow_q;
    assign busy      = (state_q != IDLE);
    assign ovf_count = ovf_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: a behavioural 3-bit signed ALU on the ALU port plus a transaction-level
// model of grant order and overflow count, checked cycle by cycle.
module tb_alu_scheduler;

    logic       clk_2 = 1'b0;
    logic       reset_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_f, req1_f;
    logic [2:0] alu_a, alu_b, alu_y;
    logic [1:0] alu_f;
    logic       alu_flow;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_flow, busy;
    logic [2:0] rsp_y;
    logic [3:0] ovf_count;

    int errs = 0;
    int checks = 0;
    bit m_last;
    int m_ovf;

    always #5 clk_2 = ~clk_2;

    alu_scheduler #(.NBITS_DATA(3), .NBITS_OP(2), .NBITS_OVF(4)) dut (
        .clk_2(clk_2), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_y(alu_y), .alu_flow(alu_flow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flow(rsp_flow),
        .busy(busy), .ovf_count(ovf_count)
    );

    // 3-bit signed ALU: overflow when the true integer result leaves [-4, 3].
    function automatic logic [3:0] alu_ref(input logic [2:0] a, input logic [2:0] b, input logic [1:0] f);
        int sa, sb, r;
        logic [2:0] y;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (f)
            2'd0: r = sa + sb;
            2'd1: r = sa - sb;
            default: r = 0;
        endcase
        if (f == 2'd2) return {a & b, 1'b0};
        if (f == 2'd3) return {a | b, 1'b0};
        y = r[2:0];
        return {y, (r > 3 || r < -4)};
    endfunction

    always_comb {alu_y, alu_flow} = alu_ref(alu_a, alu_b, alu_f);

    function automatic bit pick(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return !last;
        return v1;
    endfunction

    // One full operation: accept cycle, EXEC, RESP (optionally backpressured), response handshake.
    task automatic txn(input bit v0, input bit v1,
                       input logic [2:0] a0, input logic [2:0] b0, input logic [1:0] f0,
                       input logic [2:0] a1, input logic [2:0] b1, input logic [1:0] f1,
                       input int hold, input bit scramble);
        bit         id;
        logic [2:0] ea, eb, ey;
        logic [1:0] ef;
        logic       eflow;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_f = f0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_f = f1;
        rsp_ready = (hold == 0);
        #1;
        id = pick(v0, v1, m_last);
        ea = id ? a1 : a0; eb = id ? b1 : b0; ef = id ? f1 : f0;
        {ey, eflow} = alu_ref(ea, eb, ef);
        checks++; if (req0_ready !== (v0 && !id)) begin errs++; $display("FAIL req0_ready got=%b exp=%b", req0_ready, v0 && !id); end
        checks++; if (req1_ready !== (v1 && id)) begin errs++; $display("FAIL req1_ready got=%b exp=%b", req1_ready, v1 && id); end
        @(posedge clk_2); #1;
        m_last = id;
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errs++; $display("FAIL exec_state busy=%b rsp_valid=%b exp 1/0", busy, rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_f} !== {ea, eb, ef}) begin errs++; $display("FAIL alu_ops got=%h/%h/%h exp=%h/%h/%h", alu_a, alu_b, alu_f, ea, eb, ef); end
        checks++; if (req0_ready || req1_ready) begin errs++; $display("FAIL exec_ready got=%b%b exp=00", req0_ready, req1_ready); end
        if (scramble) begin
            req0_a = 3'($urandom); req0_b = 3'($urandom); req0_f = 2'($urandom);
            req1_a = 3'($urandom); req1_b = 3'($urandom); req1_f = 2'($urandom);
        end
        @(posedge clk_2); #1;
        checks++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if ({rsp_id, rsp_y, rsp_flow} !== {id, ey, eflow}) begin errs++; $display("FAIL rsp got id=%b y=%b fl=%b exp id=%b y=%b fl=%b", rsp_id, rsp_y, rsp_flow, id, ey, eflow); end
        checks++; if ({alu_a, alu_b, alu_f} !== {ea, eb, ef}) begin errs++; $display("FAIL alu_hold got=%h/%h/%h exp=%h/%h/%h", alu_a, alu_b, alu_f, ea, eb, ef); end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_2); #1;
            checks++; if ({rsp_valid, rsp_id, rsp_y, rsp_flow, busy} !== {1'b1, id, ey, eflow, 1'b1}) begin
                errs++; $display("FAIL bp_hold cyc=%0d got v=%b id=%b y=%b fl=%b busy=%b exp v=1 id=%b y=%b fl=%b busy=1", i, rsp_valid, rsp_id, rsp_y, rsp_flow, busy, id, ey, eflow);
            end
            checks++; if (req0_ready || req1_ready) begin errs++; $display("FAIL bp_ready got=%b%b exp=00", req0_ready, req1_ready); end
        end
        rsp_ready = 1'b1;
        @(posedge clk_2); #1;
        if (eflow && m_ovf < 15) m_ovf++;
        checks++; if (ovf_count !== 4'(m_ovf)) begin errs++; $display("FAIL ovf_count got=%0d exp=%0d", ovf_count, m_ovf); end
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL post_rsp rsp_valid=%b busy=%b exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req0_f = 0; req1_a = 0; req1_b = 0; req1_f = 0;
        #12;
        checks++; if ({busy, rsp_valid, ovf_count, alu_a, alu_b, alu_f} !== '0) begin
            errs++; $display("FAIL reset_state busy=%b v=%b ovf=%0d alu=%h/%h/%h exp all 0", busy, rsp_valid, ovf_count, alu_a, alu_b, alu_f);
        end
        checks++; if ({rsp_y, rsp_id, rsp_flow} !== '0) begin errs++; $display("FAIL reset_rsp got=%b%b%b exp=0", rsp_y, rsp_id, rsp_flow); end
        @(negedge clk_2); reset_n = 1'b1;
        m_last = 1'b1; m_ovf = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_2); #1;
            checks++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_no_req busy=%b exp=0", busy); end
        end
    endtask

    task automatic test_basic_add();
        txn(1, 0, 3'b011, 3'b001, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0);
        checks++; if (ovf_count !== 4'd1) begin errs++; $display("FAIL basic_ovf got=%0d exp=1", ovf_count); end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 10; i++)
            txn(1, 1, 3'($urandom), 3'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 0, 1);
    endtask

    task automatic test_backpressure();
        txn(1, 1, 3'b010, 3'b011, 2'b00, 3'b101, 3'b011, 2'b01, 5, 0);
        txn(1, 1, 3'($urandom), 3'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 0, 0);
    endtask

    task automatic test_single_req1();
        for (int i = 0; i < 4; i++) begin
            txn(0, 1, 3'($urandom), 3'($urandom), 2'($urandom), 3'b110, 3'b011, 2'b01, 0, 1);
            checks++; if ({rsp_id, rsp_y, rsp_flow} !== {1'b1, 3'b011, 1'b1}) begin
                errs++; $display("FAIL single_req1_last got id=%b y=%b fl=%b exp 1/011/1", rsp_id, rsp_y, rsp_flow);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++)
            txn(1, 0, 3'b011, 3'b001, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0);
        checks++; if (ovf_count !== 4'd15) begin errs++; $display("FAIL saturate got=%0d exp=15", ovf_count); end
    endtask

    task automatic test_reset_exec();
        req0_valid = 1; req0_a = 3'b011; req0_b = 3'b001; req0_f = 2'b00;
        req1_valid = 0; rsp_ready = 1;
        @(posedge clk_2); #1;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rst_exec_pre busy=%b exp=1", busy); end
        req0_valid = 0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({busy, rsp_valid, ovf_count, alu_a, alu_b, alu_f} !== '0) begin
            errs++; $display("FAIL rst_exec busy=%b v=%b ovf=%0d alu=%h/%h/%h exp all 0", busy, rsp_valid, ovf_count, alu_a, alu_b, alu_f);
        end
        m_last = 1'b1; m_ovf = 0;
        @(negedge clk_2); reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_2); #1;
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rst_no_rsp v=%b busy=%b exp 0/0", rsp_valid, busy); end
        end
        txn(1, 1, 3'($urandom), 3'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_round_robin();
        test_backpressure();
        test_single_req1();
        test_saturation();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
